// File: rtl/rand_slot_picker.sv
// ============================================================================
//  Module      : rand_slot_picker
//  Description : Reduces a pseudo-random word to a slot index 0..NUM_SLOTS-1
//                by bit-serial modulo, with optional no-repeat bumping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rand_slot_picker #(
    parameter int RAND_W    = 30,
    parameter int NUM_SLOTS = 9,
    parameter int SLOT_W    = 4,
    parameter int NO_REPEAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RAND_W-1:0] rand_in,
    input  logic              req,
    output logic              busy,
    output logic              valid,
    output logic [SLOT_W-1:0] slot
);

    localparam int                 c_CNT_W    = $clog2(RAND_W + 1);
    localparam logic [SLOT_W:0]    c_MOD      = (SLOT_W + 1)'(NUM_SLOTS);
    localparam logic [SLOT_W:0]    c_MOD_M1   = (SLOT_W + 1)'(NUM_SLOTS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(RAND_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [SLOT_W-1:0]  c_SLOT_ONE = SLOT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_ADJUST = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [RAND_W-1:0]   r_shift;
    logic [SLOT_W:0]     r_rem;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_have_last;
    logic [SLOT_W-1:0]   r_last;
    logic [SLOT_W-1:0]   r_slot;
    logic                r_busy;
    logic                r_valid;

    logic [SLOT_W:0]     w_t;
    logic [SLOT_W:0]     w_rem_next;
    logic                w_repeat;
    logic [SLOT_W-1:0]   w_result;

    // Remainder stays below NUM_SLOTS, so the shifted value is below 2*NUM_SLOTS
    // and a single conditional subtract restores the invariant.
    always_comb begin
        w_t        = {r_rem[SLOT_W-1:0], r_shift[RAND_W-1]};
        w_rem_next = (w_t >= c_MOD) ? (w_t - c_MOD) : w_t;
    end

    always_comb begin
        w_repeat = (NO_REPEAT != 0) && r_have_last && (r_rem == {1'b0, r_last});
        if (!w_repeat) begin
            w_result = r_rem[SLOT_W-1:0];
        end else if (r_rem == c_MOD_M1) begin
            w_result = '0;
        end else begin
            w_result = r_rem[SLOT_W-1:0] + c_SLOT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_have_last <= 1'b0;
            r_last      <= '0;
            r_slot      <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (req) begin
                        r_shift <= rand_in;
                        r_rem   <= '0;
                        r_cnt   <= c_CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    r_rem   <= w_rem_next;
                    r_shift <= {r_shift[RAND_W-2:0], 1'b0};
                    r_cnt   <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_ADJUST;
                    end
                end
                S_ADJUST: begin
                    r_slot      <= w_result;
                    r_last      <= w_result;
                    r_have_last <= 1'b1;
                    r_valid     <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign slot  = r_slot;

endmodule

`default_nettype wire
